rgmii_rx_framer: RTL and testbench
==================================

# rgmii_rx_framer

Receive framer for the RGMII port: consumes the registered DDR sample pairs produced by the five per-pin RX DDR input cells (RXD[3:0], RX_CTL), all clocked by `clkrx`. It assembles bytes in 1G (DDR byte) or 10/100 (SDR nibble) mode, strips preamble/SFD and delimits frames with SOF/EOF/error flags. It also decodes RGMII in-band link status from inter-frame idle. Output is a push-only byte stream for the MAC RX FIFO; there is no backpressure.

## Interface
- `MAX_LEN`, 1536: maximum frame bytes after SFD; longer frames are truncated and flagged.
- `clkrx`  in  1  RX clock from the pad; the only clock.
- `rst`  in  1  synchronous reset, active-low.
- `rxd_dq`  in  8  DDR samples; bits [2i+1:2i] come from pin RXD[i]. Bit 2i = rising-edge sample, bit 2i+1 = falling-edge sample.
- `ctl_dq`  in  2  RX_CTL samples: [0] = RX_DV (rising), [1] = RX_DV xor RX_ER (falling).
- `speed_1g`  in  1  1 = DDR byte mode, 0 = nibble mode (rising samples only).
- `m_data`  out  8  frame byte.
- `m_valid`  out  1  byte strobe.
- `m_sof`  out  1  first byte after SFD.
- `m_eof`  out  1  last byte of the frame.
- `m_err`  out  1  frame bad; valid only with `m_eof`.
- `link_up`, `link_speed[1:0]`, `link_duplex`  out  1/2/1  in-band status.

## Operation
- Reset values: every output is 0. FSM = IDLE, nibble phase = 0, length counter = 0.
- ER is decoded as `ctl_dq[1]^ctl_dq[0]`. Rising nibble `rn` = {rxd_dq[6],[4],[2],[0]}; falling nibble `fn` = odd bits.
- Byte assembly:
  - 1G mode: byte = {fn,rn} each cycle.
  - Nibble mode: byte = {second rn, first rn}, i.e. the low nibble arrives first.
- `speed_1g` is sampled only in IDLE and held for the whole frame.
- FSM:
  - IDLE: DV=0. When ctl=00, latch `rn` into status: link_up=rn[0], link_speed=rn[2:1], link_duplex=rn[3]. ctl=10 or 01 is not treated as status. DV=1 → PRE.
  - PRE: hunt for SFD 8'hD5.
    - 1G: SFD must appear on a byte.
    - Nibble mode: previous rn=5 and current rn=D sets the nibble phase so the next rn is a low nibble.
    - SFD found → DATA. DV=0 before SFD → IDLE with no output. Any number of 0x55 (including 0) is accepted before SFD.
  - DATA: each completed byte goes into a one-byte hold register; the previous hold content is emitted. The first emitted byte carries `m_sof`.
    - ER=1 while DV=1 sets a sticky error.
    - DV=0: emit the hold byte with `m_eof`; `m_err` = sticky error OR odd nibble count (the dangling nibble is discarded). Then → IDLE.
    - Length counter reaches MAX_LEN: that byte is emitted with m_eof=1, m_err=1 → DROP.
  - DROP: discard until DV=0 → IDLE.
- A frame of 1 byte asserts `m_sof` and `m_eof` together.
- `rst` low mid-frame aborts immediately; no EOF is emitted.

## Timing
- 1G: a byte present on `rxd_dq` in cycle n gives `m_valid` in cycle n+3 (input register, assembly/hold, output register). EOF appears at n+3 for the last byte even though DV falls at n+1.
- Nibble mode: the same 3-cycle latency, measured from the cycle holding the high nibble.
- Back-to-back frames with 1 idle cycle (DV=0 for one cycle) must be separated correctly.
- Status outputs update 2 cycles after the qualifying idle sample.
- `m_sof`, `m_eof` and `m_err` are 1-cycle pulses coincident with `m_valid`; all are 0 when `m_valid`=0.

## Structure
- Package `rgmii_rx_pkg`:
  - state enum {IDLE, PRE, DATA, DROP};
  - constants PREAMBLE=8'h55, SFD=8'hD5;
  - speed codes 2'b00=10M, 01=100M, 10=1G.
- Sub-module `rgmii_rx_nibble_pack`: mode-dependent byte assembly with a phase register. Outputs byte + byte_valid + odd_nibble.
- The framer FSM, hold register, length counter and status decode live in the top module.

## Test plan
- 1G frame: 7×0x55, 0xD5, bytes 0x01..0x40, DV low → 64 bytes out, SOF on 0x01, EOF on 0x40, err=0; first valid 3 cycles after 0x01 was presented.
- Nibble mode, same frame as nibbles (5,5…,5,D, 1,0,2,0…) → identical byte stream. An extra trailing nibble gives EOF with err=1.
- 1G frame with ER pulsed on byte 10 → EOF with err=1. An idle ctl=00 with rn=4'b1101 → link_up=1, link_speed=10, link_duplex=1.
- 1G frame of MAX_LEN+50 bytes → EOF+err on byte MAX_LEN, no further valid until the next frame, which is received cleanly.
- DV high for 0x55 only then drop (no SFD) → no output. Next, two frames separated by one idle cycle → both delimited with correct SOF/EOF.
- `rst` low during byte 20 → all outputs 0 the next cycle. The following frame is received normally.

Source files
------------

// File: rtl/rgmii_rx_pkg.sv
// Shared types and constants for the RGMII receive framer.
//   rx_state_e   : framer FSM states
//   link_speed_e : in-band link speed codes carried on RXD[2:1] during idle
//   PREAMBLE/SFD : frame delimiters
//   rise_nib / fall_nib : split a DDR sample word into its edge nibbles
package rgmii_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    SPEED_10M  = 2'b00,
    SPEED_100M = 2'b01,
    SPEED_1G   = 2'b10
  } link_speed_e;

  localparam logic [7:0]  PREAMBLE        = 8'h55;
  localparam logic [7:0]  SFD             = 8'hD5;
  localparam int unsigned MAX_LEN_DEFAULT = 1536;

  // Bit 2i of the DDR word is the rising-edge sample of RXD[i].
  function automatic logic [3:0] rise_nib(input logic [7:0] dq);
    return {dq[6], dq[4], dq[2], dq[0]};
  endfunction

  // Bit 2i+1 of the DDR word is the falling-edge sample of RXD[i].
  function automatic logic [3:0] fall_nib(input logic [7:0] dq);
    return {dq[7], dq[5], dq[3], dq[1]};
  endfunction

endpackage

// File: rtl/rgmii_rx_nibble_pack.sv
// Byte assembly for the RGMII receive path.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   clr_i           : hold the nibble phase at 0 (outside frame data)
//   mode_1g_i       : 1 = DDR byte per cycle, 0 = one rising nibble per cycle
//   dv_i            : receive data valid for this sample
//   dq_i            : registered DDR sample word
//   byte_o/byte_valid_o : assembled byte and its strobe
//   odd_nibble_o    : a low nibble is waiting for its high half
module rgmii_rx_nibble_pack
  import rgmii_rx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       mode_1g_i,
  input  logic       dv_i,
  input  logic [7:0] dq_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       odd_nibble_o
);

  logic [3:0] rn;
  logic [3:0] fn;
  logic       phase_q, phase_d;
  logic [3:0] low_q, low_d;

  always_comb begin
    rn           = rise_nib(dq_i);
    fn           = fall_nib(dq_i);
    phase_d      = phase_q;
    low_d        = low_q;
    byte_o       = '0;
    byte_valid_o = 1'b0;
    if (clr_i) begin
      phase_d = 1'b0;
    end else if (dv_i) begin
      if (mode_1g_i) begin
        byte_o       = {fn, rn};
        byte_valid_o = 1'b1;
      end else if (!phase_q) begin
        // Low nibble travels first in 10/100 mode.
        low_d   = rn;
        phase_d = 1'b1;
      end else begin
        byte_o       = {rn, low_q};
        byte_valid_o = 1'b1;
        phase_d      = 1'b0;
      end
    end
  end

  assign odd_nibble_o = phase_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase_q <= 1'b0;
      low_q   <= '0;
    end else begin
      phase_q <= phase_d;
      low_q   <= low_d;
    end
  end

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: registers the DDR pin samples, assembles bytes,
// strips preamble/SFD and delivers a push-only byte stream with SOF/EOF/ERR.
// Decodes in-band link status from idle samples.
//   clkrx              : RX clock (only clock)
//   rst                : synchronous reset, active low
//   rxd_dq[7:0]        : RXD DDR samples, bit 2i rising / 2i+1 falling of RXD[i]
//   ctl_dq[1:0]        : [0] RX_DV, [1] RX_DV^RX_ER
//   speed_1g           : 1 = DDR byte mode, 0 = nibble mode (taken in IDLE)
//   m_data/m_valid     : frame byte and strobe
//   m_sof/m_eof/m_err  : first byte, last byte, frame-bad (with m_eof)
//   link_up/link_speed/link_duplex : in-band status
module rgmii_rx_framer
  import rgmii_rx_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic       clkrx,
  input  logic       rst,
  input  logic [7:0] rxd_dq,
  input  logic [1:0] ctl_dq,
  input  logic       speed_1g,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_sof,
  output logic       m_eof,
  output logic       m_err,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_duplex
);

  localparam int unsigned    LW      = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0]  LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0]  LEN_ONE = LW'(1);

  // Input register stage
  logic [7:0] rxd_q;
  logic [1:0] ctl_q;

  // Framer state
  rx_state_e     state_q;
  logic          mode_q, mode_d;
  logic [3:0]    prev_rn_q;
  logic          prev_dv_q;
  logic [7:0]    hold_q;
  logic          hold_vld_q;
  logic [LW-1:0] len_q;
  logic          err_q;

  // Output registers
  logic [7:0] data_q;
  logic       valid_q, sof_q, eof_q, oerr_q;
  logic       link_up_q, link_duplex_q;
  logic [1:0] link_speed_q;

  // Decoded view of the registered sample
  logic       dv, er, sfd_hit, pack_clr;
  logic [3:0] rn, fn;
  logic [7:0] pack_byte;
  logic       pack_valid, pack_odd;

  always_comb begin
    dv       = ctl_q[0];
    er       = ctl_q[1] ^ ctl_q[0];
    rn       = rise_nib(rxd_q);
    fn       = fall_nib(rxd_q);
    mode_d   = (state_q == IDLE) ? speed_1g : mode_q;
    // Nibble mode sees the SFD as a 5 followed by a D on the rising samples.
    sfd_hit  = mode_d ? ({fn, rn} == SFD)
                      : (prev_dv_q && (prev_rn_q == PREAMBLE[3:0]) && (rn == SFD[7:4]));
    pack_clr = (state_q != DATA);
  end

  rgmii_rx_nibble_pack u_pack (
    .clk_i        (clkrx),
    .rst_ni       (rst),
    .clr_i        (pack_clr),
    .mode_1g_i    (mode_q),
    .dv_i         (dv),
    .dq_i         (rxd_q),
    .byte_o       (pack_byte),
    .byte_valid_o (pack_valid),
    .odd_nibble_o (pack_odd)
  );

  always_ff @(posedge clkrx) begin
    if (!rst) begin
      rxd_q         <= '0;
      ctl_q         <= '0;
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      prev_rn_q     <= '0;
      prev_dv_q     <= 1'b0;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      len_q         <= '0;
      err_q         <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      oerr_q        <= 1'b0;
      link_up_q     <= 1'b0;
      link_speed_q  <= '0;
      link_duplex_q <= 1'b0;
    end else begin
      rxd_q     <= rxd_dq;
      ctl_q     <= ctl_dq;
      mode_q    <= mode_d;
      prev_rn_q <= rn;
      prev_dv_q <= dv;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      oerr_q    <= 1'b0;

      case (state_q)
        IDLE, PRE: begin
          hold_vld_q <= 1'b0;
          len_q      <= '0;
          err_q      <= 1'b0;
          if (!dv) begin
            state_q <= IDLE;
            if ((state_q == IDLE) && (ctl_q == 2'b00)) begin
              link_up_q     <= rn[0];
              link_speed_q  <= rn[2:1];
              link_duplex_q <= rn[3];
            end
          end else if (sfd_hit) begin
            state_q <= DATA;
          end else begin
            state_q <= PRE;
          end
        end

        DATA: begin
          if (dv && er) begin
            err_q <= 1'b1;
          end
          // A byte leaves the hold only once the next byte completes or DV
          // drops, so the last byte can carry EOF and a dangling nibble can
          // still mark it bad.
          if (!dv) begin
            if (hold_vld_q) begin
              data_q  <= hold_q;
              valid_q <= 1'b1;
              sof_q   <= (len_q == LEN_ONE);
              eof_q   <= 1'b1;
              oerr_q  <= err_q | pack_odd;
            end
            state_q <= IDLE;
          end else if (len_q == LEN_MAX) begin
            data_q  <= hold_q;
            valid_q <= 1'b1;
            sof_q   <= (len_q == LEN_ONE);
            eof_q   <= 1'b1;
            oerr_q  <= 1'b1;
            state_q <= DROP;
          end else if (pack_valid) begin
            if (hold_vld_q) begin
              data_q  <= hold_q;
              valid_q <= 1'b1;
              sof_q   <= (len_q == LEN_ONE);
            end
            hold_q     <= pack_byte;
            hold_vld_q <= 1'b1;
            len_q      <= len_q + LEN_ONE;
          end
        end

        DROP: begin
          hold_vld_q <= 1'b0;
          len_q      <= '0;
          err_q      <= 1'b0;
          if (!dv) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign m_data      = data_q;
  assign m_valid     = valid_q;
  assign m_sof       = sof_q;
  assign m_eof       = eof_q;
  assign m_err       = oerr_q;
  assign link_up     = link_up_q;
  assign link_speed  = link_speed_q;
  assign link_duplex = link_duplex_q;

endmodule

// File: tb/tb_rgmii_rx_framer.sv
module tb_rgmii_rx_framer;

  localparam int MAXL = 1536;

  logic       clkrx = 1'b0;
  logic       rst;
  logic [7:0] rxd_dq;
  logic [1:0] ctl_dq;
  logic       speed_1g;
  logic [7:0] m_data;
  logic       m_valid, m_sof, m_eof, m_err;
  logic       link_up, link_duplex;
  logic [1:0] link_speed;

  rgmii_rx_framer #(.MAX_LEN(MAXL)) dut (
    .clkrx       (clkrx),
    .rst         (rst),
    .rxd_dq      (rxd_dq),
    .ctl_dq      (ctl_dq),
    .speed_1g    (speed_1g),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_sof       (m_sof),
    .m_eof       (m_eof),
    .m_err       (m_err),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .link_duplex (link_duplex)
  );

  always #5 clkrx = ~clkrx;

  int         ecnt = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [3:0] idle_rn = 4'h0;

  logic [7:0] q_data[$];
  bit         q_sof[$];
  bit         q_eof[$];
  bit         q_err[$];
  int         q_t[$];

  always @(posedge clkrx) ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: collects every emitted byte, and requires quiet flags otherwise.
  always @(negedge clkrx) begin
    if (mon_en) begin
      if (m_valid === 1'b1) begin
        q_data.push_back(m_data);
        q_sof.push_back(m_sof);
        q_eof.push_back(m_eof);
        q_err.push_back(m_err);
        q_t.push_back(ecnt);
      end else begin
        check("idle_flags", {29'd0, m_sof, m_eof, m_err}, 32'd0);
      end
    end
  end

  function automatic logic [7:0] enc(input logic [3:0] r, input logic [3:0] f);
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      e[2*i]   = r[i];
      e[2*i+1] = f[i];
    end
    return e;
  endfunction

  task automatic drv(input logic [7:0] d, input logic [1:0] c);
    rxd_dq = d;
    ctl_dq = c;
    @(negedge clkrx);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(enc(idle_rn, 4'h0), 2'b00);
  endtask

  task automatic clear_q();
    q_data.delete(); q_sof.delete(); q_eof.delete(); q_err.delete(); q_t.delete();
  endtask

  task automatic frame_1g(input int npre, input int n, input int er_at, input int rst_at,
                          input int flip_at, output int tf, output int tl);
    tf = 0;
    tl = 0;
    repeat (npre) drv(enc(4'h5, 4'h5), 2'b11);
    drv(enc(4'h5, 4'hD), 2'b11);
    for (int i = 1; i <= n; i++) begin
      logic [7:0] b;
      b = 8'(i);
      if (i == 1) tf = ecnt;
      tl = ecnt;
      if (i == flip_at) speed_1g = 1'b0;
      if (i == rst_at) rst = 1'b0;
      drv(enc(b[3:0], b[7:4]), (i == er_at) ? 2'b01 : 2'b11);
      if (i == rst_at) begin
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_data", {24'd0, m_data}, 32'd0);
        check("rst_flags", {29'd0, m_sof, m_eof, m_err}, 32'd0);
        check("rst_link", {28'd0, link_up, link_speed, link_duplex}, 32'd0);
        rst = 1'b1;
      end
    end
    speed_1g = 1'b1;
    idle(1);
  endtask

  task automatic frame_nib(input int npre, input int n, input bit extra);
    repeat (2 * npre + 1) drv(enc(4'h5, 4'hA), 2'b11);
    drv(enc(4'hD, 4'h2), 2'b11);
    for (int i = 1; i <= n; i++) begin
      logic [7:0] b;
      b = 8'(i);
      drv(enc(b[3:0], ~b[3:0]), 2'b11);
      drv(enc(b[7:4], ~b[7:4]), 2'b11);
    end
    if (extra) drv(enc(4'h7, 4'h8), 2'b11);
    idle(1);
  endtask

  task automatic check_frame(input string tag, input int off, input int n, input bit exp_err);
    if (q_data.size() >= off + n) begin
      for (int k = 1; k <= n; k++) begin
        int i;
        i = off + k - 1;
        check({tag, "_data"}, {24'd0, q_data[i]}, {24'd0, 8'(k)});
        check({tag, "_sof"}, {31'd0, q_sof[i]}, {31'd0, (k == 1)});
        check({tag, "_eof"}, {31'd0, q_eof[i]}, {31'd0, (k == n)});
        check({tag, "_err"}, {31'd0, q_err[i]}, {31'd0, (k == n) && exp_err});
      end
    end
  endtask

  initial begin
    int tf, tl;
    rst      = 1'b0;
    rxd_dq   = '0;
    ctl_dq   = '0;
    speed_1g = 1'b1;
    repeat (3) @(negedge clkrx);
    check("reset_valid", {31'd0, m_valid}, 32'd0);
    check("reset_data", {24'd0, m_data}, 32'd0);
    check("reset_flags", {29'd0, m_sof, m_eof, m_err}, 32'd0);
    check("reset_link", {28'd0, link_up, link_speed, link_duplex}, 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;
    idle(3);

    // In-band status: takes effect two cycles after the idle sample.
    idle_rn = 4'b1101;
    drv(enc(4'b1101, 4'h0), 2'b00);
    check("status_early", {31'd0, link_up}, 32'd0);
    drv(enc(4'h0, 4'h0), 2'b10);
    check("status_up", {31'd0, link_up}, 32'd1);
    check("status_speed", {30'd0, link_speed}, 32'd2);
    check("status_duplex", {31'd0, link_duplex}, 32'd1);
    drv(enc(4'h0, 4'h0), 2'b10);
    drv(enc(4'h0, 4'h0), 2'b10);
    check("status_ctl10", {28'd0, link_up, link_speed, link_duplex}, 32'hD);
    idle(2);

    // 1G frame 0x01..0x40
    frame_1g(7, 64, 0, 0, 0, tf, tl);
    idle(6);
    check("g64_count", q_data.size(), 64);
    if (q_data.size() == 64) begin
      check("g64_lat_first", q_t[0] - tf, 3);
      check("g64_lat_eof", q_t[63] - tl, 3);
    end
    check_frame("g64", 0, 64, 1'b0);
    clear_q();

    // Nibble mode, same frame; then a trailing odd nibble
    speed_1g = 1'b0;
    idle(2);
    frame_nib(7, 64, 1'b0);
    idle(6);
    check("n64_count", q_data.size(), 64);
    check_frame("n64", 0, 64, 1'b0);
    clear_q();
    frame_nib(2, 4, 1'b1);
    idle(6);
    check("nodd_count", q_data.size(), 4);
    check_frame("nodd", 0, 4, 1'b1);
    clear_q();
    speed_1g = 1'b1;
    idle(2);

    // ER on byte 10; speed_1g dropped mid-frame must not matter
    frame_1g(7, 20, 10, 0, 5, tf, tl);
    idle(6);
    check("er_count", q_data.size(), 20);
    check_frame("er", 0, 20, 1'b1);
    clear_q();
    check("status_after", {28'd0, link_up, link_speed, link_duplex}, 32'hD);

    // Oversize frame truncated at MAX_LEN, next frame clean
    frame_1g(7, MAXL + 50, 0, 0, 0, tf, tl);
    idle(6);
    check("long_count", q_data.size(), MAXL);
    check_frame("long", 0, MAXL, 1'b1);
    clear_q();
    frame_1g(7, 8, 0, 0, 0, tf, tl);
    idle(6);
    check("after_long_count", q_data.size(), 8);
    check_frame("after_long", 0, 8, 1'b0);
    clear_q();

    // Preamble only, no SFD
    repeat (3) drv(enc(4'h5, 4'h5), 2'b11);
    idle(8);
    check("nosfd_count", q_data.size(), 0);
    clear_q();

    // Back-to-back with one idle cycle; second frame has no preamble
    frame_1g(7, 5, 0, 0, 0, tf, tl);
    frame_1g(0, 6, 0, 0, 0, tf, tl);
    idle(6);
    check("b2b_count", q_data.size(), 11);
    check_frame("b2b_a", 0, 5, 1'b0);
    check_frame("b2b_b", 5, 6, 1'b0);
    clear_q();

    // Reset during byte 20: bytes 1..17 already out, no EOF
    frame_1g(7, 40, 0, 20, 0, tf, tl);
    idle(6);
    check("rstf_count", q_data.size(), 17);
    if (q_data.size() == 17) begin
      for (int k = 1; k <= 17; k++) begin
        check("rstf_data", {24'd0, q_data[k-1]}, {24'd0, 8'(k)});
        check("rstf_eof", {31'd0, q_eof[k-1]}, 32'd0);
      end
    end
    clear_q();
    frame_1g(3, 12, 0, 0, 0, tf, tl);
    idle(6);
    check("post_rst_count", q_data.size(), 12);
    check_frame("post_rst", 0, 12, 1'b0);
    clear_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
